// File: rtl/axi_mem_if.sv
// axi_mem_if: read/write burst channels between a master and axi_mem_slave.
interface axi_mem_if;
    logic [31:0] ar_addr;
    logic        ar_valid;
    logic        ar_ready;
    logic        r_valid;
    logic        r_ready;
    logic [63:0] r_data;
    logic        r_last;
    logic [31:0] aw_addr;
    logic        aw_valid;
    logic        aw_ready;
    logic [63:0] w_data;
    logic        w_valid;
    logic        w_ready;
    modport master (
        output ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_valid,
        input  ar_ready, r_valid, r_data, r_last, aw_ready, w_ready
    );
    modport slave (
        input  ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_valid,
        output ar_ready, r_valid, r_data, r_last, aw_ready, w_ready
    );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: 64-bit word store serving fixed 4-beat read and write bursts
// through independent read and write state machines.
module axi_mem_slave #(
    parameter int DEPTH_WORDS = 4096,
    parameter int RD_LAT      = 2,
    parameter int BEATS       = 4
) (
    input logic      clk,
    input logic      rst,
    axi_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = $clog2(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic {W_IDLE, W_DATA} w_state_t;
    logic [63:0]   mem [DEPTH_WORDS];
    r_state_t      r_state_q, r_state_d;
    w_state_t      w_state_q, w_state_d;
    logic [3:0]    r_cnt_q, r_cnt_d;
    logic [BW-1:0] r_beat_q, r_beat_d, w_beat_q, w_beat_d;
    logic [AW-1:0] r_base_q, r_base_d, w_base_q, w_base_d;
    logic [63:0]   r_data_q, r_data_d;
    logic          ar_ready_q, aw_ready_q, r_valid_q, r_last_q, w_ready_q;
    logic          r_load, w_fire;
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_beat_d  = r_beat_q;
        r_base_d  = r_base_q;
        r_load    = 1'b0;
        case (r_state_q)
            R_IDLE: if (bus.ar_valid && ar_ready_q) begin
                r_state_d = R_WAIT;
                r_cnt_d   = 4'(RD_LAT - 1);
                r_base_d  = AW'((bus.ar_addr >> 5) << 2);
            end
            R_WAIT: if (r_cnt_q == 4'd0) begin
                r_state_d = R_DATA;
                r_beat_d  = '0;
                r_load    = 1'b1;
            end else begin
                r_cnt_d = r_cnt_q - 4'd1;
            end
            R_DATA: if (bus.r_ready) begin
                if (r_beat_q == LAST) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_beat_d = r_beat_q + 1'b1;
                    r_load   = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // storage is read before this edge's write lands, so a colliding beat sees old data
        r_data_d = r_load ? mem[r_base_d + AW'(r_beat_d)] : r_data_q;
    end
    always_comb begin
        w_state_d = w_state_q;
        w_beat_d  = w_beat_q;
        w_base_d  = w_base_q;
        w_fire    = w_ready_q && bus.w_valid;
        if (bus.aw_valid && aw_ready_q) begin
            w_state_d = W_DATA;
            w_beat_d  = '0;
            w_base_d  = AW'((bus.aw_addr >> 5) << 2);
        end else if (w_fire) begin
            w_beat_d  = w_beat_q + 1'b1;
            w_state_d = (w_beat_q == LAST) ? W_IDLE : W_DATA;
        end
    end
    always_ff @(posedge clk) begin
        if (w_fire) mem[w_base_q + AW'(w_beat_q)] <= bus.w_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_IDLE;
            r_cnt_q    <= '0;
            r_beat_q   <= '0;
            w_beat_q   <= '0;
            r_base_q   <= '0;
            w_base_q   <= '0;
            r_data_q   <= '0;
            ar_ready_q <= 1'b0;
            aw_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            w_ready_q  <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            w_state_q  <= w_state_d;
            r_cnt_q    <= r_cnt_d;
            r_beat_q   <= r_beat_d;
            w_beat_q   <= w_beat_d;
            r_base_q   <= r_base_d;
            w_base_q   <= w_base_d;
            r_data_q   <= r_data_d;
            ar_ready_q <= r_state_d == R_IDLE;
            aw_ready_q <= w_state_d == W_IDLE;
            r_valid_q  <= r_state_d == R_DATA;
            r_last_q   <= (r_state_d == R_DATA) && (r_beat_d == LAST);
            w_ready_q  <= w_state_d == W_DATA;
        end
    end
    assign bus.ar_ready = ar_ready_q;
    assign bus.aw_ready = aw_ready_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_last   = r_last_q;
    assign bus.r_data   = r_data_q;
    assign bus.w_ready  = w_ready_q;
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed literal checks plus randomized traffic compared every
// cycle against a cycle-stamped behavioural model of the burst memory.
module tb_axi_mem_slave;
    localparam int DEPTH  = 4096;
    localparam int RD_LAT = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    axi_mem_if bus ();
    axi_mem_if b5 ();
    axi_mem_slave #(.DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT), .BEATS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    axi_mem_slave #(.DEPTH_WORDS(64), .RD_LAT(5), .BEATS(4)) dut5 (.clk(clk), .rst(rst), .bus(b5));
    always #5 clk = ~clk;

    task automatic cmp1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp64(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] a, input int b);
        return int'((longint'(a >> 5) * 4 + longint'(b)) % DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        return ($urandom() & 32'hFFFF_8000) | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
    endfunction

    // Behavioural model: bursts tracked by cycle stamps, storage as a plain array.
    logic [63:0] mm [DEPTH];
    bit          rbusy, wbusy, e_arr, e_awr, e_rv, e_wr, e_rl;
    int          cyc, since, rfirst, rbeat, wbeat;
    logic [31:0] raddr, waddr;
    logic [63:0] rdat;
    initial begin
        bit ar_hs, aw_hs, r_hs, w_hs;
        {rbusy, wbusy, e_arr, e_awr, e_rv, e_wr, e_rl} = '0;
        cyc = 0; since = 0; rfirst = 0; rbeat = 0; wbeat = 0;
        raddr = '0; waddr = '0; rdat = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                rbusy = 0; wbusy = 0; since = 0; rdat = '0;
            end else begin
                cyc++;
                ar_hs = bus.ar_valid && e_arr;
                aw_hs = bus.aw_valid && e_awr;
                r_hs  = bus.r_ready && e_rv;
                w_hs  = bus.w_valid && e_wr;
                if (r_hs) begin
                    if (rbeat == 3) rbusy = 0;
                    else begin
                        rbeat++;
                        rdat = mm[widx(raddr, rbeat)];
                    end
                end
                if (rbusy && cyc == rfirst) begin
                    rbeat = 0;
                    rdat  = mm[widx(raddr, 0)];
                end
                if (ar_hs) begin
                    rbusy = 1; raddr = bus.ar_addr; rfirst = cyc + RD_LAT;
                end
                if (w_hs) begin
                    mm[widx(waddr, wbeat)] = bus.w_data;
                    wbeat++;
                    if (wbeat == 4) wbusy = 0;
                end
                if (aw_hs) begin
                    wbusy = 1; waddr = bus.aw_addr; wbeat = 0;
                end
                since++;
            end
            @(negedge clk);
            e_rv  = !rst && rbusy && cyc >= rfirst;
            e_arr = !rst && since > 0 && !rbusy;
            e_awr = !rst && since > 0 && !wbusy;
            e_wr  = !rst && wbusy;
            e_rl  = e_rv && rbeat == 3;
            cmp1("m ar_ready", bus.ar_ready, e_arr);
            cmp1("m aw_ready", bus.aw_ready, e_awr);
            cmp1("m w_ready", bus.w_ready, e_wr);
            cmp1("m r_valid", bus.r_valid, e_rv);
            cmp1("m r_last", bus.r_last, e_rl);
            if (rst || e_rv) cmp64("m r_data", bus.r_data, rst ? 64'd0 : rdat);
        end
    end

    task automatic wr_burst(input logic [31:0] a, input logic [63:0] d0, d1, d2, d3);
        logic [63:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        bus.aw_addr = a; bus.aw_valid = 1'b1;
        for (int k = 0; k < 20 && !bus.aw_ready; k++) step();
        cmp1("wr aw_ready", bus.aw_ready, 1'b1);
        step();
        bus.aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.w_valid = 1'b1; bus.w_data = d[i];
            cmp1("wr w_ready", bus.w_ready, 1'b1);
            step();
        end
        bus.w_valid = 1'b0;
        cmp1("wr done w_ready", bus.w_ready, 1'b0);
        cmp1("wr done aw_ready", bus.aw_ready, 1'b1);
    endtask

    task automatic rd_burst(input logic [31:0] a, input logic [63:0] e0, e1, e2, e3,
                            input int stall_beat, input int stall_n);
        logic [63:0] e [4];
        int n;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        bus.ar_addr = a; bus.ar_valid = 1'b1; bus.r_ready = 1'b0;
        for (int k = 0; k < 20 && !bus.ar_ready; k++) step();
        cmp1("rd ar_ready", bus.ar_ready, 1'b1);
        step();
        bus.ar_valid = 1'b0;
        n = 0;
        while (!bus.r_valid && n < 40) begin step(); n++; end
        cmp64("rd latency", 64'(n), 64'(RD_LAT));
        for (int i = 0; i < 4; i++) begin
            cmp1("rd r_valid", bus.r_valid, 1'b1);
            cmp64("rd beat", bus.r_data, e[i]);
            cmp1("rd r_last", bus.r_last, i == 3);
            if (i == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    step();
                    cmp1("stall r_valid", bus.r_valid, 1'b1);
                    cmp64("stall r_data", bus.r_data, e[i]);
                    cmp1("stall ar_ready", bus.ar_ready, 1'b0);
                end
            end
            bus.r_ready = 1'b1;
            step();
            bus.r_ready = 1'b0;
        end
        cmp1("rd end r_valid", bus.r_valid, 1'b0);
    endtask

    initial begin
        int n;
        bus.ar_addr = '0; bus.ar_valid = 0; bus.r_ready = 0; bus.aw_addr = '0;
        bus.aw_valid = 0; bus.w_data = '0; bus.w_valid = 0;
        b5.ar_addr = '0; b5.ar_valid = 0; b5.r_ready = 0; b5.aw_addr = '0;
        b5.aw_valid = 0; b5.w_data = '0; b5.w_valid = 0;
        repeat (3) @(posedge clk);
        step();
        cmp1("rst ar_ready", bus.ar_ready, 1'b0);
        cmp1("rst aw_ready", bus.aw_ready, 1'b0);
        cmp1("rst r_valid", bus.r_valid, 1'b0);
        cmp1("rst w_ready", bus.w_ready, 1'b0);
        cmp64("rst r_data", bus.r_data, 64'd0);
        rst = 1'b0;
        step();
        cmp1("release ar_ready", bus.ar_ready, 1'b1);
        cmp1("release aw_ready", bus.aw_ready, 1'b1);
        b5.ar_valid = 1'b1; b5.r_ready = 1'b1;
        cmp1("lat5 ar_ready", b5.ar_ready, 1'b1);
        step();
        b5.ar_valid = 1'b0;
        n = 0;
        while (!b5.r_valid && n < 40) begin step(); n++; end
        cmp64("lat5 latency", 64'(n), 64'd5);
        for (int l = 0; l < 8; l++)
            wr_burst(32'(l * 32), 64'hC0DE_0000_0000_0000 | 64'(l * 4), 64'hC0DE_0000_0000_0001 | 64'(l * 4),
                     64'hC0DE_0000_0000_0002 | 64'(l * 4), 64'hC0DE_0000_0000_0003 | 64'(l * 4));
        wr_burst(32'h8000_0020, 64'h11, 64'h22, 64'h33, 64'h44);
        rd_burst(32'h8000_0038, 64'h11, 64'h22, 64'h33, 64'h44, -1, 0);
        rd_burst(32'h8000_0020, 64'h11, 64'h22, 64'h33, 64'h44, 1, 3);
        wr_burst(32'h0, 64'hAA, 64'hAB, 64'hAC, 64'hAD);
        bus.ar_addr = '0; bus.aw_addr = '0; bus.ar_valid = 1'b1; bus.aw_valid = 1'b1; bus.r_ready = 1'b0;
        cmp1("same ar_ready", bus.ar_ready, 1'b1);
        cmp1("same aw_ready", bus.aw_ready, 1'b1);
        step();
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0;
        step();
        bus.w_valid = 1'b1; bus.w_data = 64'h55;
        step();
        cmp1("collide r_valid", bus.r_valid, 1'b1);
        cmp64("collide old data", bus.r_data, 64'hAA);
        for (int i = 1; i < 4; i++) begin
            bus.w_data = 64'h55 + 64'(i);
            step();
        end
        bus.w_valid = 1'b0;
        cmp1("collide w done", bus.w_ready, 1'b0);
        cmp64("collide hold", bus.r_data, 64'hAA);
        bus.r_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            cmp64("collide later beat", bus.r_data, 64'h55 + 64'(i));
            cmp1("collide r_last", bus.r_last, i == 3);
        end
        step();
        bus.r_ready = 1'b0;
        cmp1("collide end", bus.r_valid, 1'b0);
        rd_burst(32'h0000_8000, 64'h55, 64'h56, 64'h57, 64'h58, -1, 0);
        bus.ar_addr = 32'h20; bus.ar_valid = 1'b1;
        for (int k = 0; k < 20 && !bus.ar_ready; k++) step();
        step();
        bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
        for (int k = 0; k < 20 && !bus.r_valid; k++) step();
        step();
        step();
        bus.r_ready = 1'b0;
        cmp64("abort beat2", bus.r_data, 64'h33);
        rst = 1'b1;
        #1;
        cmp1("abort r_valid async", bus.r_valid, 1'b0);
        cmp1("abort ar_ready", bus.ar_ready, 1'b0);
        step();
        rst = 1'b0;
        step();
        cmp1("abort release ar_ready", bus.ar_ready, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.ar_valid = ($urandom_range(0, 2) == 0);
            bus.ar_addr = rand_addr();
            bus.aw_valid = ($urandom_range(0, 2) == 0);
            bus.aw_addr = rand_addr();
            bus.r_ready = ($urandom_range(0, 3) != 0);
            bus.w_valid = ($urandom_range(0, 1) == 0);
            bus.w_data = {$urandom(), $urandom()};
            step();
        end
        rst = 1'b0; bus.ar_valid = 0; bus.aw_valid = 0; bus.w_valid = 0; bus.r_ready = 1'b1;
        repeat (20) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
